// File: rtl/aes_inv_key_sched_pkg.sv
// aes_pkg: shared AES definitions.
//   NR           number of AES-128 rounds (fixed at 10)
//   aes_state_e  key-scheduler FSM states
//   xtime        GF(2^8) multiply-by-x, used to step the round constant
//   get_word     extract column 0..3 from a 128-bit block (column 0 in [127:96])
//   rot_word     cyclic byte rotation {a,b,c,d} -> {b,c,d,a}
package aes_pkg;

  localparam logic [3:0] NR = 4'd10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    EMIT   = 2'd2
  } aes_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] get_word(input logic [127:0] blk, input logic [1:0] col);
    return blk[32*(3-col) +: 32];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_inv_key_sched_sbox.sv
// aes_sbox: combinational forward AES S-box.
//   a_i  input byte
//   s_o  substituted byte
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign s_o = SBOX[a_i];

endmodule

// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: iterative AES-128 round-key generator for decryption.
// Expands a cipher key into 11 stored round keys (one per cycle), then
// streams them round 10 down to round 0 over a valid/ready interface.
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   key_valid  cipher key offered (accepted only in IDLE)
//   key_ready  high only in IDLE
//   key        cipher key, column 0 in [127:96]
//   rk_valid   round key presented
//   rk_ready   consumer accepts the round key
//   rk         round key (zero while rk_valid is low)
//   rk_round   round index of rk, 10..0
//   rk_last    high with round 0
//   busy       high in EXPAND or EMIT
//
// state  | meaning
// IDLE   | waiting for a key, key_ready=1
// EXPAND | computing round key idx (1..10), one per cycle
// EMIT   | presenting stored round key idx, counting down to 0
module aes_inv_key_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         busy
);

  aes_state_e   state_q;
  logic [3:0]   idx_q;
  logic [7:0]   rcon_q;
  logic [127:0] store_q [11];

  logic         key_ready_q;
  logic         rk_valid_q;
  logic [127:0] rk_q;
  logic [3:0]   rk_round_q;
  logic         rk_last_q;
  logic         busy_q;

  // One index serves both phases: in EXPAND the previous key is idx-1,
  // in EMIT the next key to present after a handshake is also idx-1.
  logic [3:0]   prev_idx;
  logic [127:0] prev_rk;
  logic [31:0]  rot_w;
  logic [31:0]  sub_w;
  logic [31:0]  w0_d, w1_d, w2_d, w3_d;
  logic [127:0] rk_next_d;

  assign prev_idx = (idx_q == 4'd0) ? 4'd0 : idx_q - 4'd1;
  assign prev_rk  = store_q[prev_idx];
  assign rot_w    = rot_word(get_word(prev_rk, 2'd3));

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .a_i (rot_w[g*8 +: 8]),
      .s_o (sub_w[g*8 +: 8])
    );
  end

  assign w0_d      = get_word(prev_rk, 2'd0) ^ sub_w ^ {rcon_q, 24'h0};
  assign w1_d      = get_word(prev_rk, 2'd1) ^ w0_d;
  assign w2_d      = get_word(prev_rk, 2'd2) ^ w1_d;
  assign w3_d      = get_word(prev_rk, 2'd3) ^ w2_d;
  assign rk_next_d = {w0_d, w1_d, w2_d, w3_d};

  // Storage carries no reset; its contents only matter after a fresh accept.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && key_valid) begin
      store_q[0] <= key;
    end else if (state_q == EXPAND) begin
      store_q[idx_q] <= rk_next_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      rcon_q      <= 8'h00;
      key_ready_q <= 1'b1;
      rk_valid_q  <= 1'b0;
      rk_q        <= '0;
      rk_round_q  <= 4'd0;
      rk_last_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_valid) begin
            state_q     <= EXPAND;
            idx_q       <= 4'd1;
            rcon_q      <= 8'h01;
            key_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        EXPAND: begin
          rcon_q <= xtime(rcon_q);
          if (idx_q == NR) begin
            // Present round 10 straight from the expansion datapath;
            // the same value is being written into storage this edge.
            state_q    <= EMIT;
            rk_valid_q <= 1'b1;
            rk_q       <= rk_next_d;
            rk_round_q <= NR;
            rk_last_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        EMIT: begin
          if (rk_ready) begin
            if (idx_q == 4'd0) begin
              state_q     <= IDLE;
              rk_valid_q  <= 1'b0;
              rk_q        <= '0;
              rk_round_q  <= 4'd0;
              rk_last_q   <= 1'b0;
              busy_q      <= 1'b0;
              key_ready_q <= 1'b1;
            end else begin
              idx_q      <= idx_q - 4'd1;
              rk_q       <= prev_rk;
              rk_round_q <= idx_q - 4'd1;
              rk_last_q  <= (idx_q == 4'd1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign key_ready = key_ready_q;
  assign rk_valid  = rk_valid_q;
  assign rk        = rk_q;
  assign rk_round  = rk_round_q;
  assign rk_last   = rk_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Testbench for aes_inv_key_sched: known-answer table plus an independent
// FIPS-197 style key-expansion model feeding a scoreboard queue.
module tb_aes_inv_key_sched;

  logic         clk;
  logic         rst;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         busy;

  aes_inv_key_sched dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key       (key),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk        (rk),
    .rk_round  (rk_round),
    .rk_last   (rk_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] rk;
    logic [3:0]   round;
    logic         last;
  } exp_t;

  typedef struct {
    logic [127:0] key;
    logic [127:0] rk10;
    logic [127:0] rk1;
    logic [127:0] rk0;
  } vec_t;

  int           errors = 0;
  int           checks = 0;
  exp_t         sb_q[$];
  logic [7:0]   tb_sbox [256];
  logic [127:0] mdl [11];
  logic [127:0] got [16];
  int           cyc = 0;
  int           acc_cyc = 0;
  int           acc_count = 0;
  int           last_hs_cyc = 0;
  int           stream_hs = 0;
  logic         in_flight = 1'b0;
  logic         expect_kr = 1'b0;
  logic         stall_mode = 1'b0;
  logic         prev_stall = 1'b0;
  logic         prev_valid = 1'b0;
  logic [127:0] p_rk;
  logic [3:0]   p_round;
  logic         p_last;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // GF(2^8) arithmetic to build the S-box from first principles.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (gmul(a, 8'(c)) == 8'h01) return 8'(c);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] b);
    logic [7:0] v;
    v = ginv(b);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]], tb_sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Backpressure driver
  initial begin
    rk_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rk_ready = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor and scoreboard, sampled on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 1'b0;
        prev_valid = 1'b0;
      end else begin
        chk("ready_vs_busy", 160'(key_ready), 160'(!busy));
        if (expect_kr) begin
          chk("ready_after_last", 160'({key_ready, rk_valid}), 160'(2'b10));
          expect_kr = 1'b0;
        end
        if (!rk_valid) chk("outputs_zero_when_invalid", 160'({rk, rk_round, rk_last}), 160'(0));
        if (prev_stall)
          chk("stall_hold", 160'({rk_valid, rk, rk_round, rk_last}), 160'({1'b1, p_rk, p_round, p_last}));
        if (rk_valid && !prev_valid) chk("first_latency", 160'(cyc - acc_cyc), 160'(11));
        if (key_valid && key_ready) begin
          chk("accept_only_when_idle", 160'(in_flight), 160'(0));
          model_expand(key);
          for (int r = 10; r >= 0; r--) sb_q.push_back({mdl[r], 4'(r), (r == 0)});
          acc_cyc   = cyc;
          acc_count++;
          in_flight = 1'b1;
          stream_hs = 0;
        end
        if (rk_valid && rk_ready) begin
          stream_hs++;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rk: got round %0d rk %h, expected no output", rk_round, rk);
          end else begin
            e = sb_q.pop_front();
            chk("rk", 160'(rk), 160'(e.rk));
            chk("rk_round", 160'(rk_round), 160'(e.round));
            chk("rk_last", 160'(rk_last), 160'(e.last));
          end
          got[rk_round] = rk;
          if (rk_last) begin
            chk("handshake_count", 160'(stream_hs), 160'(11));
            in_flight   = 1'b0;
            expect_kr   = 1'b1;
            last_hs_cyc = cyc;
          end
        end
        prev_stall = rk_valid && !rk_ready;
        prev_valid = rk_valid;
        p_rk       = rk;
        p_round    = rk_round;
        p_last     = rk_last;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_key_ready"}, 160'(key_ready), 160'(1));
    chk({tag, "_rk_valid"}, 160'(rk_valid), 160'(0));
    chk({tag, "_rk"}, 160'(rk), 160'(0));
    chk({tag, "_rk_round"}, 160'(rk_round), 160'(0));
    chk({tag, "_rk_last"}, 160'(rk_last), 160'(0));
    chk({tag, "_busy"}, 160'(busy), 160'(0));
  endtask

  // Offer a key and return #1 after the accepting edge; key_valid is dropped.
  task automatic send_key(input logic [127:0] k);
    int n;
    n = acc_count;
    key = k;
    key_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (acc_count != n) break;
    end
    chk("key_accepted", 160'(acc_count != n), 160'(1));
    #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      if (!in_flight) break;
      @(posedge clk);
    end
    chk("stream_done", 160'(in_flight), 160'(0));
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    check_reset_vals(tag);
    sb_q.delete();
    in_flight = 1'b0;
    expect_kr = 1'b0;
    #1;
    rst = 1'b0;
  endtask

  task automatic clear_got();
    for (int i = 0; i < 16; i++) got[i] = {4{32'hdeadbeef}};
  endtask

  initial begin
    vec_t         vecs [2];
    logic [127:0] ka, kb;
    int           n;

    rst = 1'b1;
    key_valid = 1'b0;
    key = '0;
    for (int i = 0; i < 256; i++) tb_sbox[i] = sbox_calc(8'(i));

    vecs[0] = '{FIPS_KEY, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                128'ha0fafe1788542cb123a339392a6c7605, FIPS_KEY};
    vecs[1] = '{128'h0, 128'hb4ef5bcb3e92e21123e951cf6f8f188e,
                128'h62636363626363636263636362636363, 128'h0};

    #3;
    check_reset_vals("reset");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // Known-answer vectors, no backpressure
    for (int v = 0; v < 2; v++) begin
      clear_got();
      send_key(vecs[v].key);
      wait_done();
      chk("kat_round10", 160'(got[10]), 160'(vecs[v].rk10));
      chk("kat_round1", 160'(got[1]), 160'(vecs[v].rk1));
      chk("kat_round0", 160'(got[0]), 160'(vecs[v].rk0));
    end

    // Random backpressure on the FIPS key
    stall_mode = 1'b1;
    clear_got();
    send_key(FIPS_KEY);
    wait_done();
    chk("stall_round10", 160'(got[10]), 160'(vecs[0].rk10));
    chk("stall_round1", 160'(got[1]), 160'(vecs[0].rk1));
    chk("stall_round0", 160'(got[0]), 160'(vecs[0].rk0));
    stall_mode = 1'b0;
    @(posedge clk);
    #1;

    // key_valid held high across two back-to-back keys
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    n = acc_count;
    key = ka;
    key_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (acc_count != n) break;
    end
    chk("held_first_accept", 160'(acc_count - n), 160'(1));
    #1;
    key = kb;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (acc_count != n + 1) break;
    end
    chk("held_second_accept", 160'(acc_count - n), 160'(2));
    chk("held_accept_gap", 160'(acc_cyc - last_hs_cyc), 160'(1));
    #1;
    key_valid = 1'b0;
    wait_done();

    // Reset in the middle of EXPAND (cycle 5 after accept)
    send_key(FIPS_KEY);
    repeat (4) @(posedge clk);
    #2;
    chk("mid_expand_busy", 160'({busy, rk_valid}), 160'(2'b10));
    pulse_reset("rst_expand");

    // Reset in the middle of EMIT, after three handshakes
    @(posedge clk);
    #1;
    send_key(FIPS_KEY);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (stream_hs >= 3) break;
    end
    chk("mid_emit_handshakes", 160'(stream_hs), 160'(3));
    #2;
    pulse_reset("rst_emit");

    // Clean full stream after the resets
    @(posedge clk);
    #1;
    clear_got();
    send_key(FIPS_KEY);
    wait_done();
    chk("post_rst_round10", 160'(got[10]), 160'(vecs[0].rk10));
    chk("post_rst_round1", 160'(got[1]), 160'(vecs[0].rk1));
    chk("post_rst_round0", 160'(got[0]), 160'(vecs[0].rk0));
    chk("queue_empty", 160'(sb_q.size()), 160'(0));

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_sched.md
# aes_inv_key_sched

Iterative AES-128 round-key generator for the decryption path. Accepts a 128-bit cipher key, expands all 11 round keys into local storage, then streams them in reverse order (round 10 down to round 0) over a valid/ready interface. It feeds the AddRoundKey stage that sits directly ahead of the inverse-MixColumns stage.

## Interface
- NR, 10, number of AES rounds; fixed for AES-128, not to be overridden.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  cipher key offered.
- key_ready  out  1  block can accept a key; high only in IDLE.
- key  in  128  cipher key; column 0 in [127:96]; row 0 byte of each column in the top byte.
- rk_valid  out  1  round key presented.
- rk_ready  in  1  consumer accepts the round key.
- rk  out  128  round key, same packing as key.
- rk_round  out  4  round index of rk: 10..0.
- rk_last  out  1  high with round 0.
- busy  out  1  high in EXPAND or EMIT.

## Operation
- States: IDLE, EXPAND, EMIT.
- IDLE:
  - key_ready=1.
  - When key_valid&key_ready, store key as round key 0, set round counter=1, set rcon=8'h01, go to EXPAND.
- EXPAND: one round key per cycle, i = 1..10.
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - w1' = w1 ^ w0'.
  - w2' = w2 ^ w1'.
  - w3' = w3 ^ w2'.
  - w0..w3 are the previous round key's words [127:96]..[31:0].
  - RotWord({a,b,c,d}) = {b,c,d,a}.
  - rcon update: rcon = xtime(rcon), giving 01,02,04,08,10,20,40,80,1b,36.
  - Store the result as round key i. After i=10, go to EMIT with the emit index at 10.
- EMIT:
  - rk_valid=1, rk=stored[index], rk_round=index, rk_last=(index==0).
  - On rk_valid&rk_ready: if index==0, go to IDLE; otherwise decrement index.
- key_valid is ignored outside IDLE.
- Storage is 11×128 flops, written only in IDLE accept and EXPAND.

## Timing
- Reset values: state=IDLE, key_ready=1, rk_valid=0, rk=0, rk_round=0, rk_last=0, busy=0, counters=0.
- Latency:
  - Key accept edge = cycle 0.
  - EXPAND occupies cycles 1–10.
  - rk_valid rises in cycle 11 with round 10.
- Throughput in EMIT: one key per cycle while rk_ready=1; a full stream takes 11 handshakes.
- Backpressure: while rk_valid&!rk_ready, rk, rk_round and rk_last hold stable and rk_valid stays high.
- rk, rk_round and rk_last are 0 whenever rk_valid=0.
- After the round-0 handshake: rk_valid=0 and key_ready=1 in the next cycle. A new key is accepted no earlier than that cycle.
- key_ready is a function of state only; it has no combinational path from key_valid.
- rst asserted in any state, including mid-EXPAND or mid-EMIT:
  - Immediate return to reset values.
  - The partial stream is abandoned.
  - Storage contents are don't-care.

## Structure
- Shared package aes_pkg holds:
  - NR.
  - State enum {IDLE, EXPAND, EMIT}.
  - RCON constant table, or xtime function.
  - Byte/word packing helpers.
- Sub-module aes_sbox:
  - Combinational forward S-box, 8→8.
  - Instantiated 4× for SubWord.
  - Reusable by the encryption SubBytes stage.
- One FSM plus a 4-bit round/index counter, an 8-bit rcon register and the key storage array.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - rk_valid rises exactly 11 cycles after accept.
  - First rk = d014f9a8c9ee2589e13f0cc8b6630ca6, round 10.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Last rk = key, round 0, with rk_last=1.
- All-zero key:
  - Round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
  - Round 1 = 62636363626363636263636362636363.
  - Round 0 = 0.
- Random rk_ready backpressure on the FIPS key:
  - rk, rk_round and rk_last stable while stalled.
  - Exactly 11 handshakes with the same sequence as the unstalled run.
  - key_ready=1 the cycle after the round-0 handshake.
- key_valid held high throughout two back-to-back keys:
  - Second key accepted only after the first stream completes.
  - key_ready=0 and key_valid ignored during busy.
- rst pulsed mid-EXPAND (cycle 5) and again mid-EMIT (after 3 handshakes):
  - Outputs return to reset values asynchronously.
  - A subsequent FIPS key produces the correct full stream.
- Back-to-back keys with rk_ready=1: the second stream begins 11 cycles after its accept and contains no stale values from the first key.
